// File: rtl/wb_stage.sv
// wb_stage: MEM/WB writeback stage driving the register-file write port.
//   Accepts one retiring instruction per handshake, selects ALU result,
//   extended load data or PC+4, and issues exactly one registered write
//   pulse per committed instruction (writes to register 0 are suppressed).
// Parameters: DW datapath width (32 only), AW register address width.
// Ports:
//   clk, reset (async, active-high), flush (squash uncommitted work)
//   in_valid/in_ready handshake; in_reg_write, in_rd, in_wb_sel,
//   in_alu_result (low 2 bits = load byte offset), in_pc_plus4, in_load_type
//   mem_rvalid/mem_rdata: single-cycle load response
//   rf_wr/rf_addr/rf_data: registered write port; busy: WAIT_MEM or DRAIN
// Optional feature macro WB_FWD_EN: adds the write-through bypass ports
//   q_addr1/q_addr2 (in), q_hit1/q_hit2/q_data (out).
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_reg_write,
  input  logic [AW-1:0] in_rd,
  input  logic [1:0]    in_wb_sel,
  input  logic [DW-1:0] in_alu_result,
  input  logic [DW-1:0] in_pc_plus4,
  input  logic [2:0]    in_load_type,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_wr,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  output logic          busy
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic [DW-1:0] q_data
`endif
);

  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_MEM, DRAIN} state_t;

  state_t          state, state_next;
  logic            reg_write_q;
  logic [AW-1:0]   rd_q;
  logic [2:0]      load_type_q;
  logic [1:0]      off_q;

  logic            accept;
  logic            latch;
  logic            wr_next;
  logic [AW-1:0]   addr_next;
  logic [DW-1:0]   data_next;
  logic [DW-1:0]   ext_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign in_ready = ((state == IDLE) || (state == COMMIT)) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == WAIT_MEM) || (state == DRAIN);

  // Sub-word selection uses the offset captured at accept time.
  always_comb begin
    byte_sel = mem_rdata[8*off_q +: 8];
    half_sel = mem_rdata[16*off_q[1] +: 16];
    case (load_type_q)
      3'b001:  ext_data = {{(DW-16){half_sel[15]}}, half_sel};
      3'b010:  ext_data = {{(DW-16){1'b0}}, half_sel};
      3'b011:  ext_data = {{(DW-8){byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {{(DW-8){1'b0}}, byte_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    wr_next    = 1'b0;
    addr_next  = in_rd;
    data_next  = in_alu_result;
    case (state)
      IDLE, COMMIT: begin
        if (accept) begin
          latch = 1'b1;
          if (in_wb_sel == 2'b01) begin
            state_next = WAIT_MEM;
          end else begin
            state_next = COMMIT;
            wr_next    = in_reg_write && (in_rd != '0);
            addr_next  = in_rd;
            data_next  = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_next = IDLE;
          end else begin
            state_next = COMMIT;
            wr_next    = reg_write_q && (rd_q != '0);
            addr_next  = rd_q;
            data_next  = ext_data;
          end
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data only move on a real write so they hold while rf_wr is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      load_type_q <= '0;
      off_q       <= '0;
    end else begin
      rf_wr <= wr_next;
      if (wr_next) begin
        rf_addr <= addr_next;
        rf_data <= data_next;
      end
      if (latch) begin
        reg_write_q <= in_reg_write;
        rd_q        <= in_rd;
        load_type_q <= in_load_type;
        off_q       <= in_alu_result[1:0];
      end
    end
  end

`ifdef WB_FWD_EN
  assign q_hit1 = rf_wr && (q_addr1 == rf_addr) && (q_addr1 != '0);
  assign q_hit2 = rf_wr && (q_addr2 == rf_addr) && (q_addr2 != '0);
  assign q_data = rf_data;
`endif

endmodule
